// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if : instruction-memory bus and decoder handshake of fetch_unit
// Revision      : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        dec_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;
    logic        fetch_misaligned;

    modport master (
        output imem_req, imem_addr, instruction, pc, instr_valid, fetch_misaligned,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, stall, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc, instr_valid, fetch_misaligned,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, stall, dec_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit : PC, single-outstanding imem requests, small {pc,instr} FIFO
//              with redirect flush and one-cycle stall bubble.
//              Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam int             PTR_W      = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(BUF_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [2:0] S_HALT  = 3'd4;
`endif

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             bubble;
    logic [31:0]      buf_word [BUF_DEPTH];
    logic [31:0]      buf_pc   [BUF_DEPTH];

    logic        issue;
    logic        push;
    logic        pop;
    logic        has_data;
    logic        valid_out;
    logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_hit;
    logic misaligned;

    assign misalign_hit = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_pc     = bus.redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else if (misalign_hit) begin
            misaligned <= 1'b1;
        end
    end

    assign bus.fetch_misaligned = misaligned;
`else
    logic unused_lsbs;

    assign unused_lsbs          = &{1'b0, bus.redirect_pc[1:0]};
    assign redir_pc             = {bus.redirect_pc[31:2], 2'b00};
    assign bus.fetch_misaligned = 1'b0;
`endif

    assign has_data  = (count != '0);
    assign valid_out = has_data && !bubble;
    assign issue     = (state == S_RUN) && (count < FULL_COUNT) && !bus.redirect;
    assign push      = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    assign pop       = valid_out && bus.dec_ready && !bus.redirect;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = valid_out;
    assign bus.instruction = valid_out ? buf_word[rd_ptr] : NOP_INSTR;
    assign bus.pc          = has_data ? buf_pc[rd_ptr] : fetch_pc;

    // A redirect coinciding with the response retires that response here,
    // so there is nothing left to drain.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = S_RUN;
            S_RUN:   if (issue) state_nxt = S_WAIT;
            S_WAIT:  begin
                if (bus.imem_rvalid)   state_nxt = S_RUN;
                else if (bus.redirect) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (bus.imem_rvalid) state_nxt = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT:  state_nxt = S_HALT;
`endif
            default: state_nxt = S_IDLE;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if ((state_nxt == S_RUN) && (misaligned || misalign_hit)) begin
            state_nxt = S_HALT;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            bubble   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                req_pc <= fetch_pc;
            end
            if (bus.redirect) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                bubble   <= 1'b0;
                fetch_pc <= redir_pc;
            end else begin
                bubble <= pop && bus.stall;
                if (push) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    fetch_pc <= req_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_word[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

`default_nettype wire
